// File: rtl/slatch_bank.sv
// Bank of byte-lane-writable registers. Each channel updates its active copy
// either on the write itself or, for deferred channels, on a global commit.
module slatch_bank #(
    parameter int                  WIDTH      = 16,
    parameter int                  CHANNELS   = 4,
    parameter int                  AW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter logic [CHANNELS-1:0] DEFER_MASK = {CHANNELS{1'b0}},
    parameter logic [WIDTH-1:0]    RESET_VAL  = {WIDTH{1'b0}}
) (
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [WIDTH/8-1:0]        wr_be,
    input  logic                      commit,
    input  logic [AW-1:0]             rd_addr,
    input  logic                      rd_shadow,
    output logic [WIDTH-1:0]          rd_data,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       pending,
    output logic                      commit_ack
);

    localparam int NB = WIDTH / 8;

    function automatic logic [WIDTH-1:0] merge_lanes(
        input logic [WIDTH-1:0] old_v,
        input logic [WIDTH-1:0] new_v,
        input logic [NB-1:0]    be
    );
        logic [WIDTH-1:0] r;
        r = old_v;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                r[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return r;
    endfunction

    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic [WIDTH-1:0]    active_d [CHANNELS];
    logic [CHANNELS-1:0] pending_q;
    logic [CHANNELS-1:0] pending_d;
    logic [WIDTH-1:0]    rd_data_q;
    logic [WIDTH-1:0]    rd_data_d;
    logic                commit_ack_q;
    logic                commit_ack_d;
    logic [CHANNELS-1:0] wr_hit_s;
    logic [CHANNELS-1:0] xfer_s;
    logic                any_be_s;

    // Next-state for every channel plus the read-before-write readback mux.
    // A write landing in the same cycle as a commit is forwarded straight
    // into the active copy, so a deferred channel never lags a commit.
    always_comb begin
        any_be_s     = |wr_be;
        rd_data_d    = {WIDTH{1'b0}};
        wr_hit_s     = {CHANNELS{1'b0}};
        xfer_s       = {CHANNELS{1'b0}};
        pending_d    = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            wr_hit_s[c] = wr_en && (wr_addr == AW'(c));
            if (wr_hit_s[c]) begin
                shadow_d[c] = merge_lanes(shadow_q[c], wr_data, wr_be);
            end else begin
                shadow_d[c] = shadow_q[c];
            end

            if (!DEFER_MASK[c]) begin
                active_d[c]  = shadow_d[c];
                pending_d[c] = 1'b0;
                xfer_s[c]    = 1'b0;
            end else if (commit && (pending_q[c] || (wr_hit_s[c] && any_be_s))) begin
                active_d[c]  = shadow_d[c];
                pending_d[c] = 1'b0;
                xfer_s[c]    = 1'b1;
            end else begin
                active_d[c]  = active_q[c];
                pending_d[c] = pending_q[c] | (wr_hit_s[c] & any_be_s);
                xfer_s[c]    = 1'b0;
            end

            rd_data_d = rd_data_d |
                        ((rd_addr == AW'(c)) ? (rd_shadow ? shadow_q[c] : active_q[c])
                                             : {WIDTH{1'b0}});
        end
        commit_ack_d = commit && (|xfer_s);
    end

    // State registers; reset wins over any write or commit in the same cycle.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                shadow_q[c] <= RESET_VAL;
                active_q[c] <= RESET_VAL;
            end
            pending_q    <= {CHANNELS{1'b0}};
            rd_data_q    <= {WIDTH{1'b0}};
            commit_ack_q <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                shadow_q[c] <= shadow_d[c];
                active_q[c] <= active_d[c];
            end
            pending_q    <= pending_d;
            rd_data_q    <= rd_data_d;
            commit_ack_q <= commit_ack_d;
        end
    end

    // Flatten the active copies onto q.
    always_comb begin
        q = {(CHANNELS*WIDTH){1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            q[c*WIDTH +: WIDTH] = active_q[c];
        end
    end

    assign rd_data    = rd_data_q;
    assign pending    = pending_q;
    assign commit_ack = commit_ack_q;

endmodule

// File: tb/tb_slatch_bank.sv
// Directed plus random checks of slatch_bank (3 channels, ch1/ch2 deferred)
// against a rule-level reference model.
module tb_slatch_bank;

    localparam int         W    = 16;
    localparam int         CH   = 3;
    localparam logic [2:0] DEF  = 3'b110;
    localparam logic [15:0] RV  = 16'hA5A5;

    logic          sys_clk;
    logic          reset;
    logic          wr_en;
    logic [1:0]    wr_addr;
    logic [15:0]   wr_data;
    logic [1:0]    wr_be;
    logic          commit;
    logic [1:0]    rd_addr;
    logic          rd_shadow;
    logic [15:0]   rd_data;
    logic [47:0]   q;
    logic [2:0]    pending;
    logic          commit_ack;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_sh [CH];
    logic [15:0] m_ac [CH];
    logic [2:0]  m_pend;
    logic [15:0] m_rd;
    logic        m_ack;

    slatch_bank #(
        .WIDTH(W), .CHANNELS(CH), .AW(2), .DEFER_MASK(DEF), .RESET_VAL(RV)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .commit(commit), .rd_addr(rd_addr),
        .rd_shadow(rd_shadow), .rd_data(rd_data), .q(q), .pending(pending),
        .commit_ack(commit_ack)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: apply the documented rules to the pre-edge state.
    task automatic model(input logic rst, input logic we, input logic [1:0] wa,
                         input logic [15:0] wd, input logic [1:0] be, input logic cm,
                         input logic [1:0] ra, input logic rs);
        logic [15:0] ns;
        logic        written;
        logic        any_xfer;
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_sh[c] = RV;
                m_ac[c] = RV;
            end
            m_pend = 3'b000;
            m_rd   = 16'h0000;
            m_ack  = 1'b0;
        end else begin
            if (int'(ra) < CH) m_rd = rs ? m_sh[ra] : m_ac[ra];
            else               m_rd = 16'h0000;
            any_xfer = 1'b0;
            for (int c = 0; c < CH; c++) begin
                ns = m_sh[c];
                written = 1'b0;
                if (we && int'(wa) == c) begin
                    if (be[0]) ns[7:0]  = wd[7:0];
                    if (be[1]) ns[15:8] = wd[15:8];
                    written = (be != 2'b00);
                end
                m_sh[c] = ns;
                if (!DEF[c]) begin
                    m_ac[c] = ns;
                    m_pend[c] = 1'b0;
                end else if (cm && (m_pend[c] || written)) begin
                    m_ac[c] = ns;
                    m_pend[c] = 1'b0;
                    any_xfer = 1'b1;
                end else begin
                    m_pend[c] = m_pend[c] | written;
                end
            end
            m_ack = cm && any_xfer;
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic we,
                        input logic [1:0] wa, input logic [15:0] wd, input logic [1:0] be,
                        input logic cm, input logic [1:0] ra, input logic rs);
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        commit = cm; rd_addr = ra; rd_shadow = rs;
        @(posedge sys_clk);
        model(rst, we, wa, wd, be, cm, ra, rs);
        #1;
        chk({tag, ".q"},       64'(q),          64'({m_ac[2], m_ac[1], m_ac[0]}));
        chk({tag, ".pending"}, 64'(pending),    64'(m_pend));
        chk({tag, ".rd_data"}, 64'(rd_data),    64'(m_rd));
        chk({tag, ".ack"},     64'(commit_ack), 64'(m_ack));
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 16'h0000;
        wr_be = 2'b00; commit = 1'b0; rd_addr = 2'd0; rd_shadow = 1'b0;

        // Reset for two cycles
        step("rst0", 1'b1, 1'b0, 2'd0, 16'h0000, 2'b00, 1'b0, 2'd0, 1'b0);
        step("rst1", 1'b1, 1'b0, 2'd0, 16'h0000, 2'b00, 1'b0, 2'd0, 1'b0);
        chk("rst_q",    64'(q),          64'h0000_A5A5_A5A5_A5A5);
        chk("rst_pend", 64'(pending),    64'h0);
        chk("rst_rd",   64'(rd_data),    64'h0);
        chk("rst_ack",  64'(commit_ack), 64'h0);

        // Immediate byte write to ch0; readback is read-before-write
        step("imm_wr", 1'b0, 1'b1, 2'd0, 16'h1234, 2'b01, 1'b0, 2'd0, 1'b0);
        chk("imm_q0",   64'(q[15:0]),  64'hA534);
        chk("imm_pend", 64'(pending),  64'h0);
        chk("imm_rbw",  64'(rd_data),  64'hA5A5);
        step("imm_rd", 1'b0, 1'b0, 2'd0, 16'h0000, 2'b00, 1'b0, 2'd0, 1'b0);
        chk("imm_rd0",  64'(rd_data),  64'hA534);

        // Deferred write then commit
        step("def_wr", 1'b0, 1'b1, 2'd1, 16'hBEEF, 2'b11, 1'b0, 2'd1, 1'b1);
        chk("def_q1",   64'(q[31:16]), 64'hA5A5);
        chk("def_pend", 64'(pending),  64'h2);
        step("def_rds", 1'b0, 1'b0, 2'd0, 16'h0000, 2'b00, 1'b0, 2'd1, 1'b1);
        chk("def_shadow", 64'(rd_data), 64'hBEEF);
        step("def_cm", 1'b0, 1'b0, 2'd0, 16'h0000, 2'b00, 1'b1, 2'd1, 1'b0);
        chk("def_cm_q1",  64'(q[31:16]),  64'hBEEF);
        chk("def_cm_ack", 64'(commit_ack), 64'h1);
        chk("def_cm_pend", 64'(pending),   64'h0);
        step("def_idle", 1'b0, 1'b0, 2'd0, 16'h0000, 2'b00, 1'b0, 2'd1, 1'b0);
        chk("def_ack_once", 64'(commit_ack), 64'h0);

        // Simultaneous write + commit with nothing pending
        step("zero_ch1", 1'b0, 1'b1, 2'd1, 16'h0000, 2'b11, 1'b1, 2'd0, 1'b0);
        step("idle0",    1'b0, 1'b0, 2'd0, 16'h0000, 2'b00, 1'b0, 2'd0, 1'b0);
        step("sim_wc",   1'b0, 1'b1, 2'd1, 16'hFFFF, 2'b10, 1'b1, 2'd0, 1'b0);
        chk("sim_q1",   64'(q[31:16]),   64'hFF00);
        chk("sim_pend", 64'(pending),    64'h0);
        chk("sim_ack",  64'(commit_ack), 64'h1);

        // Null commit, out-of-range write and read
        step("null_cm", 1'b0, 1'b0, 2'd0, 16'h0000, 2'b00, 1'b1, 2'd0, 1'b0);
        chk("null_ack", 64'(commit_ack), 64'h0);
        step("bad_wr",  1'b0, 1'b1, 2'd3, 16'h1111, 2'b11, 1'b0, 2'd3, 1'b0);
        chk("bad_rd",   64'(rd_data), 64'h0);
        chk("bad_q",    64'(q),       64'h0000_A5A5_FF00_A534);
        step("bad_rds", 1'b0, 1'b0, 2'd0, 16'h0000, 2'b00, 1'b0, 2'd3, 1'b1);
        chk("bad_rd_sh", 64'(rd_data), 64'h0);

        // Reset mid-operation with a commit in the same cycle
        step("mid_wr",  1'b0, 1'b1, 2'd2, 16'h5555, 2'b11, 1'b0, 2'd0, 1'b0);
        chk("mid_pend", 64'(pending), 64'h4);
        step("mid_rst", 1'b1, 1'b0, 2'd0, 16'h0000, 2'b00, 1'b1, 2'd0, 1'b0);
        chk("mid_q",    64'(q),          64'h0000_A5A5_A5A5_A5A5);
        chk("mid_pend0", 64'(pending),   64'h0);
        chk("mid_ack",  64'(commit_ack), 64'h0);
        step("mid_idle", 1'b0, 1'b0, 2'd0, 16'h0000, 2'b00, 1'b0, 2'd2, 1'b0);
        chk("mid_ack2", 64'(commit_ack), 64'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step("rnd",
                 ($urandom_range(59, 0) == 0),
                 1'($urandom_range(1, 0)),
                 2'($urandom_range(3, 0)),
                 16'($urandom),
                 2'($urandom_range(3, 0)),
                 ($urandom_range(3, 0) == 0),
                 2'($urandom_range(3, 0)),
                 1'($urandom_range(1, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
